// File: rtl/rr_encoder_arbiter_pkg.sv
// rtl/rr_encoder_arbiter_pkg.sv - shared constants for the round-robin encoder arbiter
// Purpose: holds the default requester count that the interface, the
//          encoder and the top all start from.
// Ports:   none (package)
package rr_encoder_arbiter_pkg;

  localparam int RR_DEFAULT_N = 32;

endpackage : rr_encoder_arbiter_pkg

// File: rtl/rr_encoder_arbiter_if.sv
// rtl/rr_encoder_arbiter_if.sv - request/grant bundle for the round-robin encoder arbiter
// Purpose: groups the request vector, flush and the grant handshake.
// Ports:   none; modports:
//          master - arbiter side: drives gnt_valid/gnt_idx/gnt_onehot/ptr,
//                   reads req/flush/gnt_ready
//          slave  - requester/consumer side: the mirror of master
interface rr_encoder_arbiter_if
  import rr_encoder_arbiter_pkg::*;
#(
  parameter int N = RR_DEFAULT_N
) ();

  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         flush;
  logic         gnt_valid;
  logic         gnt_ready;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic [W-1:0] ptr;

  modport master (
    input  req,
    input  flush,
    input  gnt_ready,
    output gnt_valid,
    output gnt_idx,
    output gnt_onehot,
    output ptr
  );

  modport slave (
    output req,
    output flush,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_idx,
    input  gnt_onehot,
    input  ptr
  );

endinterface : rr_encoder_arbiter_if

// File: rtl/rr_encoder_arbiter_prio_encoder.sv
// rtl/rr_encoder_arbiter_prio_encoder.sv - lowest-set-bit-first priority encoder
// Purpose: combinational encoder returning the index of the lowest set bit.
// Ports:   i_vec   [N]  input vector
//          o_idx   [W]  index of the lowest set bit (0 when none)
//          o_found      at least one bit of i_vec is set
module prio_encoder
  import rr_encoder_arbiter_pkg::*;
#(
  parameter int N = RR_DEFAULT_N
) (
  input  logic [N-1:0]         i_vec,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_found
);

  localparam int W = $clog2(N);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule : prio_encoder

// File: rtl/rr_encoder_arbiter.sv
// rtl/rr_encoder_arbiter.sv - round-robin arbiter producing a registered index + one-hot grant
// Purpose: picks one of N requesters with a rotating priority pointer and
//          holds the grant on a valid/ready handshake until accepted.
// Ports:   clk    system clock, rising edge
//          reset  synchronous active-high reset, overrides everything
//          bus    rr_encoder_arbiter_if.master: req, flush, gnt_ready in;
//                 gnt_valid, gnt_idx, gnt_onehot, ptr out (all registered)
module rr_encoder_arbiter
  import rr_encoder_arbiter_pkg::*;
#(
  parameter int N = RR_DEFAULT_N
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_encoder_arbiter_if.master  bus
);

  localparam int           W    = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic         r_gnt_valid;
  logic [W-1:0] r_gnt_idx;
  logic [N-1:0] r_gnt_onehot;
  logic [W-1:0] r_ptr;

  logic [N-1:0] w_req;
  logic [N-1:0] w_cand;
  logic [N-1:0] w_therm;
  logic [N-1:0] w_masked;
  logic [W-1:0] w_hi_idx;
  logic         w_hi_found;
  logic [W-1:0] w_all_idx;
  logic         w_all_found;
  logic [W-1:0] w_winner;
  logic [W-1:0] w_next_ptr;
  logic         w_load;

  assign w_req = bus.req;

  // Drop the grant being accepted this cycle so a persistent requester
  // cannot win twice in a row while others are waiting.
  assign w_cand = w_req & ~(r_gnt_valid ? r_gnt_onehot : '0);

  // Thermometer of positions at or above the priority pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_therm
    localparam logic [W:0] IDX = (W + 1)'(gi);
    assign w_therm[gi] = (IDX >= {1'b0, r_ptr});
  end

  assign w_masked = w_cand & w_therm;

  prio_encoder #(.N(N)) u_pe_hi (
    .i_vec   (w_masked),
    .o_idx   (w_hi_idx),
    .o_found (w_hi_found)
  );

  prio_encoder #(.N(N)) u_pe_all (
    .i_vec   (w_cand),
    .o_idx   (w_all_idx),
    .o_found (w_all_found)
  );

  // Nothing at/above ptr means the search wraps to the lowest candidate.
  assign w_winner   = w_hi_found ? w_hi_idx : w_all_idx;
  assign w_next_ptr = (w_winner == LAST) ? '0 : w_winner + W'(1);
  assign w_load     = !r_gnt_valid || bus.gnt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_ptr        <= '0;
    end else if (bus.flush) begin
      // Drop the pending grant; index and pointer keep their history.
      r_gnt_valid  <= 1'b0;
      r_gnt_onehot <= '0;
    end else if (w_load) begin
      if (w_all_found) begin
        r_gnt_valid  <= 1'b1;
        r_gnt_idx    <= w_winner;
        r_gnt_onehot <= {{(N - 1){1'b0}}, 1'b1} << w_winner;
        r_ptr        <= w_next_ptr;
      end else begin
        r_gnt_valid  <= 1'b0;
        r_gnt_onehot <= '0;
      end
    end
  end

  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.gnt_idx    = r_gnt_idx;
  assign bus.gnt_onehot = r_gnt_onehot;
  assign bus.ptr        = r_ptr;

endmodule : rr_encoder_arbiter

// File: tb/tb_rr_encoder_arbiter.sv
// tb/tb_rr_encoder_arbiter.sv - directed self-checking bench for rr_encoder_arbiter
module tb_rr_encoder_arbiter;

  logic clk;
  logic rst_a;
  logic rst_b;

  int checks = 0;
  int errors = 0;

  rr_encoder_arbiter_if #(.N(32)) bus_a ();
  rr_encoder_arbiter_if #(.N(6))  bus_b ();

  rr_encoder_arbiter #(.N(32)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  rr_encoder_arbiter #(.N(6)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic v, input int idx, input int p);
    logic [63:0] oh;
    oh = v ? (64'd1 << idx) : 64'd0;
    check({tag, ".valid"},  64'(bus_a.gnt_valid),  64'(v));
    check({tag, ".idx"},    64'(bus_a.gnt_idx),    64'(idx));
    check({tag, ".onehot"}, 64'(bus_a.gnt_onehot), oh);
    check({tag, ".ptr"},    64'(bus_a.ptr),        64'(p));
  endtask

  task automatic check_b(input string tag, input logic v, input int idx, input int p);
    logic [63:0] oh;
    oh = v ? (64'd1 << idx) : 64'd0;
    check({tag, ".valid"},  64'(bus_b.gnt_valid),  64'(v));
    check({tag, ".idx"},    64'(bus_b.gnt_idx),    64'(idx));
    check({tag, ".onehot"}, 64'(bus_b.gnt_onehot), oh);
    check({tag, ".ptr"},    64'(bus_b.ptr),        64'(p));
  endtask

  initial begin
    logic [31:0] toggles [4];
    toggles[0] = 32'hFFFF_FFFF;
    toggles[1] = 32'h0000_0000;
    toggles[2] = 32'h5555_5555;
    toggles[3] = 32'hAAAA_AAAA;

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req       = '1;
    bus_a.flush     = 1'b0;
    bus_a.gnt_ready = 1'b0;
    bus_b.req       = '0;
    bus_b.flush     = 1'b0;
    bus_b.gnt_ready = 1'b0;
    step();
    step();
    check_a("reset_a", 1'b0, 0, 0);
    check_b("reset_b", 1'b0, 0, 0);

    // All requesters active: 0 first, then a full rotation 1..31,0.
    rst_a = 1'b0;
    bus_a.gnt_ready = 1'b1;
    step();
    check_a("first", 1'b1, 0, 1);
    for (int j = 1; j <= 32; j++) begin
      step();
      check_a($sformatf("rot%0d", j), 1'b1, j % 32, (j % 32 + 1) % 32);
    end

    // Park ptr at 3 with the output idle, then req=0x84.
    bus_a.req = 32'h0000_0004;
    step();
    check_a("park2", 1'b1, 2, 3);
    bus_a.req = 32'h0;
    step();
    check_a("idle", 1'b0, 2, 3);
    bus_a.req = 32'h0000_0084;
    step();
    check_a("wrap7a", 1'b1, 7, 8);
    step();
    check_a("wrap2", 1'b1, 2, 3);
    step();
    check_a("wrap7b", 1'b1, 7, 8);

    // Hold: grant 5 pending while consumer stalls and req toggles.
    bus_a.req = 32'h0000_0020;
    step();
    check_a("hold_g5", 1'b1, 5, 6);
    bus_a.gnt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_a.req = toggles[k];
      step();
      check_a($sformatf("hold%0d", k), 1'b1, 5, 6);
    end
    bus_a.req = 32'h0000_0101;
    bus_a.gnt_ready = 1'b1;
    step();
    check_a("after_hold", 1'b1, 8, 9);

    // Lone persistent requester is granted every second cycle.
    bus_a.req = 32'h0000_0001;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_a($sformatf("single%0d", k), (k % 2) == 1, 0, 1);
    end

    // Flush together with accept while requests are pending.
    bus_a.req = 32'h0000_0C00;
    step();
    check_a("pre_flush", 1'b1, 10, 11);
    bus_a.flush = 1'b1;
    step();
    check_a("flush", 1'b0, 10, 11);
    bus_a.flush = 1'b0;
    step();
    check_a("resume", 1'b1, 11, 12);

    // Reset wins over flush.
    rst_a = 1'b1;
    bus_a.flush = 1'b1;
    step();
    check_a("rst_over_flush", 1'b0, 0, 0);
    rst_a = 1'b0;
    bus_a.flush = 1'b0;

    // N=6: park ptr at 5, then req=6'b100001 alternates 5 and 0.
    rst_b = 1'b0;
    bus_b.gnt_ready = 1'b1;
    bus_b.req = 6'b010000;
    step();
    check_b("b_park4", 1'b1, 4, 5);
    bus_b.req = 6'b000000;
    step();
    check_b("b_idle", 1'b0, 4, 5);
    bus_b.req = 6'b100001;
    step();
    check_b("b_g5", 1'b1, 5, 0);
    step();
    check_b("b_g0", 1'b1, 0, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k % 2 == 0) check_b($sformatf("b_alt%0d", k), 1'b1, 5, 0);
      else            check_b($sformatf("b_alt%0d", k), 1'b1, 0, 1);
      check($sformatf("b_range%0d", k), 64'(bus_b.gnt_idx < 3'd6), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_encoder_arbiter
